// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the IF_ID, ID_EX, EX_MEM and MEM_WB pipeline registers and the PC.
// Folds stall requests, EX branch redirects and MEM exceptions into hold/flush/redirect controls.
module pipeline_ctrl #(
    parameter int unsigned                 ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0]       EXC_VECTOR  = 32'hBFC0_0380,
    parameter int unsigned                 WDOG_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            stall_req,
    input  logic                  branch_valid,
    input  logic [ADDR_WIDTH-1:0] branch_target,
    input  logic                  exc_valid,
    input  logic [ADDR_WIDTH-1:0] exc_pc,
    output logic                  pc_en,
    output logic                  pc_redirect,
    output logic [ADDR_WIDTH-1:0] pc_redirect_addr,
    output logic [3:0]            hold,
    output logic [3:0]            flush,
    output logic [ADDR_WIDTH-1:0] epc,
    output logic                  stall_timeout
);

    localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_MAX  = WDOG_W'(WDOG_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic {
        ST_RUN,
        ST_EXC
    } state_e;

    typedef struct packed {
        logic       pc_en;
        logic [3:0] hold;
        logic [3:0] flush;
    } stall_ctl_t;

    // The highest requesting stage bubbles; every younger register and the PC hold.
    function automatic stall_ctl_t stall_decode(input logic [3:0] req);
        stall_ctl_t c;
        c.pc_en = 1'b1;
        c.hold  = 4'b0000;
        c.flush = 4'b0000;
        if (req[3]) begin
            c.pc_en = 1'b0;
            c.hold  = 4'b0111;
            c.flush = 4'b1000;
        end else if (req[2]) begin
            c.pc_en = 1'b0;
            c.hold  = 4'b0011;
            c.flush = 4'b0100;
        end else if (req[1]) begin
            c.pc_en = 1'b0;
            c.hold  = 4'b0001;
            c.flush = 4'b0010;
        end else if (req[0]) begin
            c.pc_en = 1'b0;
            c.flush = 4'b0001;
        end
        return c;
    endfunction

    state_e                  state_q, state_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [ADDR_WIDTH-1:0]   pend_addr_q, pend_addr_d;
    logic [ADDR_WIDTH-1:0]   epc_q, epc_d;
    logic [WDOG_W-1:0]       wdog_q, wdog_d;
    logic                    timeout_q, timeout_d;

    stall_ctl_t              dec;
    logic                    ctl_pc_en;
    logic                    ctl_redirect;
    logic [ADDR_WIDTH-1:0]   ctl_addr;
    logic [3:0]              ctl_hold;
    logic [3:0]              ctl_flush;
    logic                    older_stall;

    assign older_stall = |stall_req[3:2];

    // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        dec          = stall_decode(stall_req);
        state_d      = ST_RUN;
        pend_vld_d   = pend_vld_q;
        pend_addr_d  = pend_addr_q;
        epc_d        = epc_q;
        ctl_pc_en    = dec.pc_en;
        ctl_redirect = 1'b0;
        ctl_addr     = '0;
        ctl_hold     = dec.hold;
        ctl_flush    = dec.flush;

        if (exc_valid) begin
            ctl_pc_en    = 1'b1;
            ctl_redirect = 1'b1;
            ctl_addr     = EXC_VECTOR;
            ctl_hold     = 4'b0000;
            ctl_flush    = 4'b1111;
            epc_d        = exc_pc;
            pend_vld_d   = 1'b0;
            state_d      = ST_EXC;
        end else if (state_q == ST_EXC) begin
            // Squash the two wrong-path fetches; a flushed register never also holds.
            ctl_flush = dec.flush | 4'b0011;
            ctl_hold  = dec.hold & ~ctl_flush;
        end else if (older_stall) begin
            if (branch_valid) begin
                pend_vld_d  = 1'b1;
                pend_addr_d = branch_target;
            end
        end else if (branch_valid || pend_vld_q) begin
            // A fresh branch in the release cycle is younger than the parked one and wins.
            ctl_pc_en    = 1'b1;
            ctl_redirect = 1'b1;
            ctl_addr     = branch_valid ? branch_target : pend_addr_q;
            ctl_hold     = 4'b0000;
            ctl_flush    = 4'b0011;
            pend_vld_d   = 1'b0;
        end
    end

    // Watchdog counts consecutive held cycles and saturates so the pulse fires once per episode.
    always_comb begin
        wdog_d    = wdog_q;
        timeout_d = 1'b0;
        if (exc_valid || ctl_hold == 4'b0000) begin
            wdog_d = '0;
        end else begin
            timeout_d = (wdog_q == WDOG_LAST);
            if (wdog_q != WDOG_MAX) begin
                wdog_d = wdog_q + WDOG_W'(1);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            pend_vld_q  <= 1'b0;
            pend_addr_q <= '0;
            epc_q       <= '0;
            wdog_q      <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_vld_q  <= pend_vld_d;
            pend_addr_q <= pend_addr_d;
            epc_q       <= epc_d;
            wdog_q      <= wdog_d;
            timeout_q   <= timeout_d;
        end
    end

    // While reset is asserted the pipeline is frozen with every register bubbled.
    always_comb begin
        if (!rst) begin
            pc_en            = 1'b0;
            pc_redirect      = 1'b0;
            pc_redirect_addr = '0;
            hold             = 4'b0000;
            flush            = 4'b1111;
        end else begin
            pc_en            = ctl_pc_en;
            pc_redirect      = ctl_redirect;
            pc_redirect_addr = ctl_addr;
            hold             = ctl_hold;
            flush            = ctl_flush;
        end
    end

    assign epc           = epc_q;
    assign stall_timeout = timeout_q;

endmodule
